ysyx_22040632_memarb: RTL
=========================

YSYX_22040632_MEMARB -- requirements
Module: ysyx_22040632_memarb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width on all ports.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge; rst_n  input  1  asynchronous reset, active low.
REQ-003 SHALL have ports: ic_req_valid  in  1  icache read request; ic_req_ready  out  1  request accepted; ic_req_addr  in  ADDR_W  start address; ic_req_len  in  8  beats minus 1; ic_rsp_valid  out  1  read beat for icache.
REQ-004 SHALL have ports: dc_req_valid  in  1  dcache request; dc_req_ready  out  1  request accepted; dc_req_addr  in  ADDR_W  start address; dc_req_write  in  1  1=write; dc_req_size  in  3  log2 bytes per beat; dc_req_len  in  8  beats minus 1.
REQ-005 SHALL have ports: dc_wvalid  in  1  write beat valid; dc_wready  out  1  write beat taken; dc_wdata  in  64  write data; dc_wstrb  in  8  byte strobes; dc_rsp_valid  out  1  read beat or write completion for dcache.
REQ-006 SHALL have ports: mem_req_valid  out  1; mem_req_ready  in  1; mem_req_addr  out  ADDR_W; mem_req_write  out  1; mem_req_size  out  3; mem_req_len  out  8; all forming the memory request channel.
REQ-007 SHALL have ports: mem_wvalid  out  1; mem_wready  in  1; mem_wdata  out  64; mem_wstrb  out  8; mem_wlast  out  1; mem_rsp_valid  in  1  read beat; mem_rsp_last  in  1  final read beat; mem_bvalid  in  1  write done.
REQ-008 SHALL leave read data unrouted: both caches sample the memory read-data bus directly, qualified by their own rsp_valid.

Function
REQ-009 SHALL implement FSM IDLE, REQ, WDATA, WAIT_R, WAIT_B; owner register OWN (IC/DC) and round-robin pointer LAST.
REQ-010 In IDLE with one valid request, SHALL grant that requester; with both valid, SHALL grant the one not equal to LAST; move to REQ next cycle.
REQ-011 In REQ SHALL drive mem_req_* from the registered request; IC requests use write=0, size=3; on mem_req_valid&&mem_req_ready go to WDATA (write) or WAIT_R (read).
REQ-012 Requester ready SHALL pulse for exactly the cycle of the mem_req handshake, never in IDLE or to the non-owner.
REQ-013 WDATA SHALL pass dc_wdata/dc_wstrb/dc_wvalid to mem and mem_wready to dc_wready; beat counter counts from 0; mem_wlast=1 when counter==len; after last handshake go to WAIT_B.
REQ-014 WAIT_R SHALL route mem_rsp_valid only to the owner's rsp_valid (combinational, zero latency); on mem_rsp_valid&&mem_rsp_last go to IDLE.
REQ-015 WAIT_B SHALL assert dc_rsp_valid for the single cycle of mem_bvalid, then go to IDLE.
REQ-016 LAST SHALL update to OWN when returning to IDLE; no new grant in the completion cycle (1 idle cycle minimum between transactions).
REQ-017 Requests SHALL NOT be preempted; a request deasserting before its handshake is a protocol error, outcome unspecified.
REQ-018 mem_rsp_valid/mem_bvalid arriving in IDLE or REQ SHALL be ignored; no rsp_valid asserted.
REQ-019 len=255 SHALL be supported; beat counter is 8 bits, wraps never occurring within a transaction.

Reset
REQ-020 On rst_n low, immediately: state=IDLE, OWN=IC, LAST=DC (IC wins first tie), counter=0, all valid/ready/wlast outputs 0, even mid-transaction.

Structure
REQ-021 Package ysyx_22040632_memarb_pkg SHALL hold the state enum, owner enum and BEAT_W=8 constant.
REQ-022 Round-robin grant logic SHALL be sub-module ysyx_22040632_rr2 (2 requesters, pointer input, one-hot grant).

Verification
REQ-023 Both request at once after reset -> IC granted first (ic_req_ready pulse), DC granted on following transaction.
REQ-024 IC read len=1 at 0x8000_0000, mem returns 2 beats -> ic_rsp_valid exactly 2 cycles, dc_rsp_valid 0.
REQ-025 DC write len=1, mem_wready low 3 cycles -> beats held stable, mem_wlast on beat 2 only, dc_rsp_valid 1 cycle on mem_bvalid.
REQ-026 DC held valid continuously with IC -> grants alternate IC,DC,IC,DC.
REQ-027 rst_n low during WAIT_R beat 1 -> all outputs 0 same cycle; after release IDLE, IC wins tie.

Source files
------------

// File: rtl/ysyx_22040632_memarb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, bus owner, beat width.
package ysyx_22040632_memarb_pkg;
  localparam int BEAT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WDATA,
    S_WAIT_R,
    S_WAIT_B
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;
endpackage

// File: rtl/ysyx_22040632_rr2.sv
// Two-way round-robin grant: a tie goes to the requester that did not own the bus last.
module ysyx_22040632_rr2
  import ysyx_22040632_memarb_pkg::*;
(
  input  logic [1:0] req,    // [0]=icache, [1]=dcache
  input  owner_t     last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_IC) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/ysyx_22040632_memarb.sv
// Arbitrates icache reads and dcache reads/writes onto one burst memory port.
// Read data is not routed here; caches sample the memory bus on their rsp_valid.
module ysyx_22040632_memarb
  import ysyx_22040632_memarb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic [7:0]        ic_req_len,
  output logic              ic_rsp_valid,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_write,
  input  logic [2:0]        dc_req_size,
  input  logic [7:0]        dc_req_len,
  input  logic              dc_wvalid,
  output logic              dc_wready,
  input  logic [63:0]       dc_wdata,
  input  logic [7:0]        dc_wstrb,
  output logic              dc_rsp_valid,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_write,
  output logic [2:0]        mem_req_size,
  output logic [7:0]        mem_req_len,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  output logic              mem_wlast,
  input  logic              mem_rsp_valid,
  input  logic              mem_rsp_last,
  input  logic              mem_bvalid
);
  state_t              state, state_n;
  owner_t              own, last;
  logic [1:0]          grant;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_write;
  logic [2:0]          req_size;
  logic [BEAT_W-1:0]   req_len, cnt;
  logic                w_hs, w_last;

  ysyx_22040632_rr2 u_rr2 (
    .req   ({dc_req_valid, ic_req_valid}),
    .last  (last),
    .grant (grant)
  );

  assign w_hs   = dc_wvalid && mem_wready;
  assign w_last = (cnt == req_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      own       <= OWN_IC;
      last      <= OWN_DC;
      cnt       <= '0;
      req_addr  <= '0;
      req_write <= 1'b0;
      req_size  <= 3'd0;
      req_len   <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && grant != 2'b00) begin
        own       <= grant[1] ? OWN_DC : OWN_IC;
        req_addr  <= grant[1] ? dc_req_addr  : ic_req_addr;
        req_write <= grant[1] ? dc_req_write : 1'b0;
        req_size  <= grant[1] ? dc_req_size  : 3'd3;
        req_len   <= grant[1] ? dc_req_len   : ic_req_len;
        cnt       <= '0;
      end
      if (state == S_WDATA && w_hs)
        cnt <= w_last ? '0 : cnt + BEAT_W'(1);
      // Pointer moves only on completion, so the idle cycle after it arbitrates fairly.
      if (state != S_IDLE && state_n == S_IDLE)
        last <= own;
    end
  end

  always_comb begin
    state_n       = state;
    mem_req_valid = 1'b0;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    mem_wvalid    = 1'b0;
    mem_wlast     = 1'b0;
    dc_wready     = 1'b0;
    ic_rsp_valid  = 1'b0;
    dc_rsp_valid  = 1'b0;
    case (state)
      S_IDLE: if (grant != 2'b00) state_n = S_REQ;
      S_REQ: begin
        mem_req_valid = 1'b1;
        ic_req_ready  = (own == OWN_IC) && mem_req_ready;
        dc_req_ready  = (own == OWN_DC) && mem_req_ready;
        if (mem_req_ready) state_n = req_write ? S_WDATA : S_WAIT_R;
      end
      S_WDATA: begin
        mem_wvalid = dc_wvalid;
        dc_wready  = mem_wready;
        mem_wlast  = w_last;
        if (w_hs && w_last) state_n = S_WAIT_B;
      end
      S_WAIT_R: begin
        ic_rsp_valid = (own == OWN_IC) && mem_rsp_valid;
        dc_rsp_valid = (own == OWN_DC) && mem_rsp_valid;
        if (mem_rsp_valid && mem_rsp_last) state_n = S_IDLE;
      end
      S_WAIT_B: begin
        dc_rsp_valid = mem_bvalid;
        if (mem_bvalid) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem_req_addr  = req_addr;
  assign mem_req_write = req_write;
  assign mem_req_size  = req_size;
  assign mem_req_len   = req_len;
  assign mem_wdata     = dc_wdata;
  assign mem_wstrb     = dc_wstrb;
endmodule
